// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parameterised single-clock FIFO with registered or first-word-fall-through read
module sync_fifo_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int AF_TH  = (2**ADDR_W) - 2,
    parameter int AE_TH  = 2,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              flush,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_TH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_TH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              rd_acc, wr_acc;

    // Status is decoded straight from the count register so it tracks count on the same edge.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A full FIFO may still take a write when a read frees the head slot at the same edge.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (wr_en && !wr_acc) overflow_d  = 1'b1;
            if (rd_en && !rd_acc) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data = mem_q[rd_ptr_q];
        end else begin : g_reg
            logic [DATA_W-1:0] rd_data_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                  rd_data_q <= '0;
                else if (rd_acc && !flush) rd_data_q <= mem_q[rd_ptr_q];
            end
            assign rd_data = rd_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - bench for sync_fifo_param in both read modes against a queue model
module tb_sync_fifo_param;

    localparam int DEPTH = 16;
    localparam int AF_TH = 14;
    localparam int AE_TH = 2;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       flush;

    logic [7:0] rd_data0, rd_data1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0] count0, count1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mq [$];
    logic       m_ovf;
    logic       m_unf;
    logic [7:0] m_rd0;

    sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .FWFT(0)) u_fifo_reg (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .flush(flush),
        .rd_data(rd_data0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(count0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .FWFT(1)) u_fifo_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .flush(flush),
        .rd_data(rd_data1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [10:0] exp_status();
        int n;
        n = mq.size();
        return {5'(n), n == DEPTH, n == 0, n >= AF_TH, n <= AE_TH, m_ovf, m_unf};
    endfunction

    // Queue model: occupancy is the queue size, the FWFT head is mq[0].
    always @(posedge clk or posedge rst) begin
        bit racc, wacc;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rd0 = 8'h00;
        end else if (flush) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            racc = rd_en && (mq.size() != 0);
            wacc = wr_en && ((mq.size() < DEPTH) || racc);
            if (rd_en && !racc) m_unf = 1'b1;
            if (wr_en && !wacc) m_ovf = 1'b1;
            if (racc) m_rd0 = mq.pop_front();
            if (wacc) mq.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        check("status_reg",  {count0, full0, empty0, af0, ae0, ovf0, unf0}, exp_status());
        check("status_fwft", {count1, full1, empty1, af1, ae1, ovf1, unf1}, exp_status());
        check("rd_data_reg", rd_data0, m_rd0);
        if (mq.size() != 0) check("rd_data_fwft", rd_data1, mq[0]);
    end

    task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic f);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        wr_en = 0; wr_data = 0; rd_en = 0; flush = 0; rst = 0;
        #1 rst = 1;
        @(negedge clk);
        check("rst_count", count0, 0);
        check("rst_empty", empty0, 1);
        check("rst_full", full0, 0);
        check("rst_ae", ae0, 1);
        check("rst_af", af0, 0);
        check("rst_flags", {ovf0, unf0}, 0);
        check("rst_rd_data", rd_data0, 0);
        rst = 0;

        for (int i = 1; i <= 16; i++) begin
            cycle(1, 8'(i), 0, 0);
            if (i == 13) check("af_after_13", af0, 0);
            if (i == 14) check("af_after_14", af0, 1);
            if (i == 15) check("full_after_15", full0, 0);
        end
        check("full_after_16", full0, 1);
        check("count_full", count0, 16);

        cycle(1, 8'h99, 0, 0);
        check("overflow_17th", ovf0, 1);
        check("count_17th", count0, 16);

        for (int i = 1; i <= 16; i++) begin
            cycle(0, 8'h00, 1, 0);
            check("rd_seq", rd_data0, 32'(i));
        end
        check("empty_after_reads", empty0, 1);
        cycle(0, 8'h00, 1, 0);
        check("underflow_extra", unf0, 1);
        check("rd_hold", rd_data0, 8'h10);

        cycle(0, 8'h00, 0, 1);
        check("flush_flags", {ovf0, unf0}, 0);
        check("flush_rd_hold", rd_data0, 8'h10);

        for (int i = 0; i < 16; i++) cycle(1, 8'(8'h21 + i), 0, 0);
        cycle(1, 8'hAA, 1, 0);
        check("full_rw_count", count0, 16);
        check("full_rw_no_ovf", ovf0, 0);
        check("full_rw_rd", rd_data0, 8'h21);
        for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1, 0);
        check("aa_last", rd_data0, 8'hAA);
        check("aa_empty", empty0, 1);

        cycle(1, 8'h55, 1, 0);
        check("empty_rw_unf", unf0, 1);
        check("empty_rw_count", count0, 1);
        check("empty_rw_fwft", rd_data1, 8'h55);
        check("empty_rw_reg_hold", rd_data0, 8'hAA);

        for (int i = 0; i < 4; i++) cycle(1, 8'(8'h60 + i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 8'(8'h70 + i), 1, 0);
            if (i == 0) check("wrap_first", rd_data0, 8'h55);
        end
        check("wrap_count", count0, 5);
        check("wrap_fwft_head", rd_data1, 8'h7F);
        cycle(0, 8'h00, 0, 1);
        check("flush_count", count0, 0);
        check("flush_empty", empty0, 1);
        check("flush_clear", {ovf0, unf0}, 0);

        for (int i = 0; i < 7; i++) cycle(1, 8'(8'hC0 + i), 0, 0);
        check("pre_rst_count", count0, 7);
        #2 rst = 1;
        #1;
        check("async_rst_count", {count0, count1}, 0);
        check("async_rst_empty", {empty0, empty1}, 2'b11);
        @(negedge clk);
        rst = 0;
        cycle(1, 8'h77, 0, 0);
        check("post_rst_count", count0, 1);
        check("post_rst_fwft", rd_data1, 8'h77);
        cycle(0, 8'h00, 1, 0);
        check("post_rst_rd", rd_data0, 8'h77);
        check("post_rst_empty", empty0, 1);

        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
